// File: rtl/counter_sequence_checker.sv
// ---------------------------------------------------------------------------
// counter_sequence_checker
//
// Passive monitor for the output of a WIDTH-bit up-counter. It samples q on
// every rising clk edge and checks that the counter only ever does one of four
// things: hold its value, step by +1, wrap from max to 0, or return to 0
// because the upstream counter was reset. Wraps are counted. Illegal steps and
// excessive holds raise sticky flags for debug and interrupt logic. This block
// never drives the counter.
//
// Parameters
//   WIDTH      width of the monitored count q
//   WRAP_W     width of the wrap counter wrap_cnt
//   MAX_HOLD   consecutive hold samples in TRACK that raise stall
//
// Ports
//   clk        in   1        single clock, all logic on posedge
//   rst        in   1        synchronous, active-low reset
//   en         in   1        monitor enable; low forces IDLE on the next edge
//   q          in   WIDTH    count value from the upstream counter
//   clr_err    in   1        one-cycle pulse: clears step_err/stall (and irq),
//                            moves ERROR back to SYNC
//   wrap_cnt   out  WRAP_W   number of wraps seen, modulo 2^WRAP_W
//   wrap_pulse out  1        registered 1-cycle pulse after a max->0 wrap
//   step_err   out  1        sticky: illegal transition seen
//   stall      out  1        sticky: q held for MAX_HOLD samples in TRACK
//   state      out  2        FSM state: 0 IDLE, 1 SYNC, 2 TRACK, 3 ERROR
//
// Optional feature, macro CSC_IRQ_EN
//   Defined: adds ports wrap_cmp (in, WRAP_W) and irq (out, 1). irq is sticky;
//   it is set the cycle after wrap_cnt increments to wrap_cmp, or the cycle
//   after step_err or stall rises. clr_err or reset clears it; a new set
//   condition in the same cycle as clr_err wins.
//   Undefined: wrap_cmp, irq and their logic are absent.
//
// Every output is registered: the decision made on sample q(n) becomes
// visible just after edge n.
// ---------------------------------------------------------------------------
module counter_sequence_checker #(
    parameter int WIDTH    = 4,
    parameter int WRAP_W   = 8,
    parameter int MAX_HOLD = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  q,
    input  logic              clr_err,
`ifdef CSC_IRQ_EN
    input  logic [WRAP_W-1:0] wrap_cmp,
    output logic              irq,
`endif
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              step_err,
    output logic              stall,
    output logic [1:0]        state
);

    // Hold counter is wide enough to hold MAX_HOLD and saturates there.
    localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);

    localparam logic [WIDTH-1:0]  Q_MAX    = '1;
    localparam logic [WIDTH-1:0]  Q_ONE    = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_PRE = HOLD_W'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        TRACK = 2'd2,
        ERROR = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Datapath registers and their next values.
    logic [WIDTH-1:0]  prev;
    logic [WIDTH-1:0]  prev_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [HOLD_W-1:0] hold_inc;
    logic              wrap_pulse_nxt;
    logic [WRAP_W-1:0] wrap_cnt_nxt;
    logic              step_err_nxt;
    logic              stall_nxt;

    // Classification of the current sample against the previous one.
    logic is_hold;
    logic is_step;
    logic is_zero;
    logic is_wrap;
    logic is_bad;

    // clr_err is honoured only while enabled and outside IDLE; a disabled
    // monitor keeps its sticky status untouched until it is re-armed.
    logic clr_ok;

    always_comb begin
        is_hold  = (q == prev);
        is_step  = (prev != Q_MAX) && (q == prev + Q_ONE);
        is_zero  = (q == '0);
        // A return to zero from max is a wrap; from anywhere else it is an
        // upstream reset, which is legal but not counted.
        is_wrap  = is_zero && (prev == Q_MAX);
        is_bad   = !(is_hold || is_step || is_zero);
        clr_ok   = en && clr_err && (state_q != IDLE);
        hold_inc = (hold_cnt == HOLD_LIM) ? hold_cnt : hold_cnt + HOLD_ONE;
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic. en low always wins and returns to IDLE, so any
    // re-enable has to pass through SYNC before checking resumes.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = SYNC;
                SYNC:    state_d = TRACK;
                TRACK:   if (is_bad) state_d = ERROR;
                ERROR:   if (clr_err) state_d = SYNC;
                default: state_d = IDLE;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // FSM: output logic. Computes the next value of every registered output
    // and of the prev/hold tracking registers.
    // -----------------------------------------------------------------------
    always_comb begin
        prev_nxt       = prev;
        hold_nxt       = hold_cnt;
        wrap_pulse_nxt = 1'b0;
        wrap_cnt_nxt   = wrap_cnt;
        step_err_nxt   = step_err;
        stall_nxt      = stall;

        // Clear first so that a violation detected below in the same cycle
        // overrides it.
        if (clr_ok) begin
            step_err_nxt = 1'b0;
            stall_nxt    = 1'b0;
        end

        if (en) begin
            unique case (state_q)
                SYNC: begin
                    prev_nxt = q;
                    hold_nxt = '0;
                end
                TRACK: begin
                    prev_nxt = q;
                    if (is_hold) begin
                        hold_nxt = hold_inc;
                        // stall is raised on the sample where the hold count
                        // reaches MAX_HOLD, not on every saturated cycle, so
                        // a clr_err during a long hold is not undone.
                        if (hold_cnt == HOLD_PRE) begin
                            stall_nxt = 1'b1;
                        end
                    end else if (is_wrap) begin
                        hold_nxt       = '0;
                        wrap_pulse_nxt = 1'b1;
                        wrap_cnt_nxt   = wrap_cnt + WRAP_ONE;
                    end else if (is_step || is_zero) begin
                        hold_nxt = '0;
                    end else begin
                        step_err_nxt = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Datapath / output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            prev       <= '0;
            hold_cnt   <= '0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
            stall      <= 1'b0;
        end else begin
            prev       <= prev_nxt;
            hold_cnt   <= hold_nxt;
            wrap_pulse <= wrap_pulse_nxt;
            wrap_cnt   <= wrap_cnt_nxt;
            step_err   <= step_err_nxt;
            stall      <= stall_nxt;
        end
    end

    assign state = state_q;

`ifdef CSC_IRQ_EN
    // -----------------------------------------------------------------------
    // Interrupt. wrap_pulse is high exactly in the cycle after wrap_cnt has
    // incremented, so it qualifies the compare against wrap_cmp. step_err and
    // stall are edge-detected against their values one cycle earlier.
    // -----------------------------------------------------------------------
    logic step_err_q1;
    logic stall_q1;
    logic irq_set;

    always_comb begin
        irq_set = (wrap_pulse && (wrap_cnt == wrap_cmp))
               || (step_err && !step_err_q1)
               || (stall && !stall_q1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            irq         <= 1'b0;
            step_err_q1 <= 1'b0;
            stall_q1    <= 1'b0;
        end else begin
            step_err_q1 <= step_err;
            stall_q1    <= stall;
            if (irq_set) begin
                irq <= 1'b1;
            end else if (clr_ok) begin
                irq <= 1'b0;
            end
        end
    end
`endif

endmodule
